// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : UART serial receive stage. Detects the start bit on the RX line,
//             samples 8N1 frames at mid-bit with a down-counting clock divider,
//             and presents each good byte on rx_data with a one-cycle rx_end
//             strobe. A low stop bit raises a one-cycle rx_ferr strobe and
//             parks the receiver until the line returns high.
//  Config   : UART_RX_SYNC_EN - when defined, rx passes through a two-flop
//             synchroniser (reset value 1) before any use, adding two cycles
//             to every latency. When undefined, rx is used directly.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DIV_RATE  = 260,  // clk cycles per bit, >= 4
    parameter int DIV_CNT_W = 9     // 2**DIV_CNT_W must exceed DIV_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_busy,
    output logic       rx_end,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_BREAK = 2'd2
    } state_t;

    // The counter samples on the cycle it is found at zero, so the start-bit
    // load is one short of half a bit: the start sample then lands exactly
    // DIV_RATE/2 cycles after detection, i.e. in the middle of the start bit.
    localparam logic [DIV_CNT_W-1:0] c_START_LOAD = DIV_CNT_W'(DIV_RATE / 2 - 1);
    // Reload after every sample so consecutive samples are DIV_RATE apart.
    localparam logic [DIV_CNT_W-1:0] c_BIT_LOAD   = DIV_CNT_W'(DIV_RATE - 1);
    localparam logic [DIV_CNT_W-1:0] c_DIV_ONE    = DIV_CNT_W'(1);
    localparam logic [3:0]           c_BIT_START  = 4'd0;
    localparam logic [3:0]           c_BIT_STOP   = 4'd9;

    // ------------------------------------------------------------------------
    // Sampled line
    // ------------------------------------------------------------------------
    logic w_rx_s;

`ifdef UART_RX_SYNC_EN
    logic sync_meta_q;
    logic sync_q;

    // Two-flop synchroniser; resets to the idle (high) line level so that
    // leaving reset can never look like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta_q <= 1'b1;
            sync_q      <= 1'b1;
        end else begin
            sync_meta_q <= rx;
            sync_q      <= sync_meta_q;
        end
    end

    assign w_rx_s = sync_q;
`else
    assign w_rx_s = rx;
`endif

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t                 state_q,   state_d;
    logic [DIV_CNT_W-1:0]   div_cnt_q, div_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;   // 0 = start, 1..8 data, 9 = stop
    logic [7:0]             shift_q,   shift_d;
    logic [7:0]             data_q,    data_d;
    logic                   end_q,     end_d;
    logic                   ferr_q,    ferr_d;
    logic                   busy_q,    busy_d;

    // Register all state; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= 8'h00;
            end_q     <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            end_q     <= end_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic: start detection, mid-bit sampling, stop-bit check.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        end_d     = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    state_d   = ST_RECV;
                    div_cnt_d = c_START_LOAD;
                    bit_cnt_d = c_BIT_START;
                end
            end

            ST_RECV: begin
                if (div_cnt_q != '0) begin
                    div_cnt_d = div_cnt_q - c_DIV_ONE;
                end else begin
                    div_cnt_d = c_BIT_LOAD;
                    if (bit_cnt_q == c_BIT_START) begin
                        // A line back high at mid-start was only a glitch.
                        if (w_rx_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end else if (bit_cnt_q == c_BIT_STOP) begin
                        bit_cnt_d = c_BIT_START;
                        if (w_rx_s) begin
                            data_d  = shift_q;
                            end_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            // Keep the previous byte; wait out the low line.
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        // LSB arrives first, so shift in from the top.
                        shift_d   = {w_rx_s, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            ST_BREAK: begin
                // Only a return to high re-arms; a held-low line never retriggers.
                if (w_rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign rx_busy = busy_q;
    assign rx_end  = end_q;
    assign rx_data = data_q;
    assign rx_ferr = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx at DIV_RATE=16. A timeline model
//             of the receiver predicts every output each cycle; directed
//             frames add hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int DIV_RATE  = 16;
    localparam int DIV_CNT_W = 5;
    localparam int HALF      = DIV_RATE / 2;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT  = 2;
`else
    localparam int SYNC_LAT  = 0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_FRAME = 1;
    localparam int M_BREAK = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_busy;
    logic       rx_end;
    logic [7:0] rx_data;
    logic       rx_ferr;

    int checks   = 0;
    int failures = 0;

    uart_rx #(
        .DIV_RATE  (DIV_RATE),
        .DIV_CNT_W (DIV_CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_busy (rx_busy),
        .rx_end  (rx_end),
        .rx_data (rx_data),
        .rx_ferr (rx_ferr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Timeline model: a frame is a detection edge t0 followed by samples at
    // t0+HALF (start), t0+HALF+k*DIV_RATE for data bit k=1..8, and the stop
    // bit at t0+HALF+9*DIV_RATE.
    // ------------------------------------------------------------------------
    int         cyc = 0;
    int         m_mode = M_IDLE;
    int         t0 = 0;
    int         off;
    int         k;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_data = 8'h00;
    logic       m_end = 1'b0;
    logic       m_ferr = 1'b0;
    logic       h1 = 1'b1;
    logic       h2 = 1'b1;
    logic       rxs;

    // monitors for literal checks
    int         end_cnt = 0;
    int         ferr_cnt = 0;
    int         last_end_cyc = 0;
    int         busy_run = 0;
    int         last_busy_len = 0;
    logic [7:0] end_q[$];

    // Model step on every edge, then compare all outputs just after it.
    always @(posedge clk) begin
        cyc++;
        rxs = (SYNC_LAT == 2) ? h2 : rx;
        if (reset) begin
            m_mode = M_IDLE;
            m_data = 8'h00;
            m_end  = 1'b0;
            m_ferr = 1'b0;
            h1     = 1'b1;
            h2     = 1'b1;
        end else begin
            m_end  = 1'b0;
            m_ferr = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (rxs == 1'b0) begin
                        m_mode = M_FRAME;
                        t0     = cyc;
                    end
                end
                M_FRAME: begin
                    off = cyc - t0;
                    if (off == HALF) begin
                        if (rxs) m_mode = M_IDLE;
                    end else if (off > HALF && ((off - HALF) % DIV_RATE) == 0) begin
                        k = (off - HALF) / DIV_RATE;
                        if (k <= 8) begin
                            m_byte[k-1] = rxs;
                        end else if (rxs) begin
                            m_data = m_byte;
                            m_end  = 1'b1;
                            m_mode = M_IDLE;
                        end else begin
                            m_ferr = 1'b1;
                            m_mode = M_BREAK;
                        end
                    end
                end
                default: begin
                    if (rxs) m_mode = M_IDLE;
                end
            endcase
            h2 = h1;
            h1 = rx;
        end

        #1;
        check("rx_busy", {31'd0, rx_busy}, {31'd0, (m_mode != M_IDLE)});
        check("rx_end",  {31'd0, rx_end},  {31'd0, m_end});
        check("rx_ferr", {31'd0, rx_ferr}, {31'd0, m_ferr});
        check("rx_data", {24'd0, rx_data}, {24'd0, m_data});

        if (rx_end === 1'b1) begin
            end_cnt++;
            end_q.push_back(rx_data);
            last_end_cyc = cyc;
        end
        if (rx_ferr === 1'b1) ferr_cnt++;
        if (rx_busy === 1'b1) begin
            busy_run++;
        end else if (busy_run > 0) begin
            last_busy_len = busy_run;
            busy_run      = 0;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus (rx changes on the falling edge only)
    // ------------------------------------------------------------------------
    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    int t_fall;

    task automatic send_frame(input logic [7:0] b, input logic stop);
        t_fall = cyc;
        hold(1'b0, DIV_RATE);
        for (int i = 0; i < 8; i++) hold(b[i], DIV_RATE);
        hold(stop, DIV_RATE);
    endtask

    int base_end;
    int base_ferr;

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {31'd0, rx_busy}, 32'd0);
        check("reset_end",  {31'd0, rx_end},  32'd0);
        check("reset_data", {24'd0, rx_data}, 32'h00);
        hold(1'b1, 10);

        // 1: frame 0x55
        base_end = end_cnt;
        send_frame(8'h55, 1'b1);
        hold(1'b1, 20);
        check("t1_end_count", end_cnt - base_end, 32'd1);
        check("t1_data", {24'd0, end_q[base_end]}, 32'h55);
        check("t1_latency", last_end_cyc - t_fall - 1, 152 + SYNC_LAT);
        check("t1_busy_len", last_busy_len, 32'd152);
        check("t1_ferr_count", ferr_cnt, 32'd0);

        // 2: 4-cycle low glitch
        hold(1'b0, 4);
        hold(1'b1, 30);
        check("t2_end_count", end_cnt - base_end, 32'd1);
        check("t2_data", {24'd0, rx_data}, 32'h55);
        check("t2_busy_len", last_busy_len, 32'd8);

        // 3: 0xA3 with low stop bit, line held low 40 more cycles
        base_end  = end_cnt;
        base_ferr = ferr_cnt;
        send_frame(8'hA3, 1'b0);
        hold(1'b0, 40);
        check("t3_busy_in_break", {31'd0, rx_busy}, 32'd1);
        check("t3_ferr_count", ferr_cnt - base_ferr, 32'd1);
        hold(1'b1, 200);
        check("t3_busy_after", {31'd0, rx_busy}, 32'd0);
        check("t3_end_count", end_cnt - base_end, 32'd0);
        check("t3_ferr_total", ferr_cnt - base_ferr, 32'd1);
        check("t3_data", {24'd0, rx_data}, 32'h55);

        // 4: 0x00 then 0xFF back-to-back
        base_end = end_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, 20);
        check("t4_end_count", end_cnt - base_end, 32'd2);
        if (end_cnt - base_end == 2) begin
            check("t4_first",  {24'd0, end_q[base_end]},     32'h00);
            check("t4_second", {24'd0, end_q[base_end + 1]}, 32'hFF);
        end

        // 5: reset during data bit 4 of 0x3C, then a full 0x3C
        hold(1'b0, DIV_RATE);
        hold(1'b0, DIV_RATE);
        hold(1'b0, DIV_RATE);
        hold(1'b1, DIV_RATE);
        hold(1'b1, HALF);
        reset = 1'b1;
        rx    = 1'b1;
        @(posedge clk);
        #2;
        check("t5_busy",  {31'd0, rx_busy}, 32'd0);
        check("t5_end",   {31'd0, rx_end},  32'd0);
        check("t5_ferr",  {31'd0, rx_ferr}, 32'd0);
        check("t5_data",  {24'd0, rx_data}, 32'h00);
        @(negedge clk);
        reset = 1'b0;
        hold(1'b1, 20);
        base_end = end_cnt;
        send_frame(8'h3C, 1'b1);
        hold(1'b1, 20);
        check("t5_end_count", end_cnt - base_end, 32'd1);
        check("t5_data_after", {24'd0, rx_data}, 32'h3C);

        // 6: 0x81 (latency includes the synchroniser when enabled)
        base_end = end_cnt;
        send_frame(8'h81, 1'b1);
        hold(1'b1, 20);
        check("t6_end_count", end_cnt - base_end, 32'd1);
        check("t6_data", {24'd0, rx_data}, 32'h81);
        check("t6_latency", last_end_cyc - t_fall - 1, 152 + SYNC_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
